// File: rtl/uvmt_cv32e40s_obi_latency_tracker.sv
`default_nettype none
// ============================================================================
// Module      : uvmt_cv32e40s_obi_latency_tracker
// Description : Age FIFO of outstanding in-order OBI transactions on one bus;
//               flags response-latency misses and FIFO over/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module uvmt_cv32e40s_obi_latency_tracker #(
    parameter  int MAX_STALLS      = 8,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int AGE_W           = $clog2(MAX_STALLS + 3),
    localparam int IDX_W           = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             addr_hs_i,
    input  logic             rsp_hs_i,
    output logic [OUT_W-1:0] outstanding_o,
    output logic [AGE_W-1:0] oldest_age_o,
    output logic             must_rsp_o,
    output logic             rsp_late_o,
    output logic [31:0]      late_cnt_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [AGE_W-1:0] AGE_MAX   = '1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_STALLS + 1);
    localparam logic [OUT_W-1:0] CNT_FULL  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(MAX_OUTSTANDING - 1);

    logic [AGE_W-1:0]           ages [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] live;
    logic [IDX_W-1:0]           rd_ptr;
    logic [IDX_W-1:0]           wr_ptr;
    logic [OUT_W-1:0]           count;
    logic                       rsp_late;
    logic [31:0]                late_cnt;
    logic                       overflow;
    logic                       underflow;

    logic             empty;
    logic             full;
    logic [AGE_W-1:0] head_age;
    logic             must_rsp;
    logic             retire;
    logic             alloc;
    logic             miss_first;

    assign empty      = (count == '0);
    assign full       = (count == CNT_FULL);
    assign head_age   = ages[rd_ptr];
    assign must_rsp   = !empty && (head_age >= AGE_LIMIT);
    assign retire     = rsp_hs_i && !empty;
    // A full FIFO still accepts a new entry when the head leaves in the same cycle.
    assign alloc      = addr_hs_i && (!full || retire);
    // Count a miss only on the first cycle past the limit; the age keeps growing afterwards.
    assign miss_first = must_rsp && !rsp_hs_i && (head_age == AGE_LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ages[i] <= '0;
            end
            live      <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            rsp_late  <= 1'b0;
            late_cnt  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ages[i] <= '0;
            end
            live      <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            rsp_late  <= 1'b0;
            late_cnt  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (alloc && (IDX_W'(i) == wr_ptr)) begin
                    ages[i] <= AGE_W'(1);
                    live[i] <= 1'b1;
                end else if (retire && (IDX_W'(i) == rd_ptr)) begin
                    ages[i] <= '0;
                    live[i] <= 1'b0;
                end else if (live[i] && (ages[i] != AGE_MAX)) begin
                    ages[i] <= ages[i] + AGE_W'(1);
                end
            end

            if (retire) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + IDX_W'(1);
            end
            if (alloc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + IDX_W'(1);
            end

            case ({alloc, retire})
                2'b10:   count <= count + OUT_W'(1);
                2'b01:   count <= count - OUT_W'(1);
                default: count <= count;
            endcase

            if (miss_first) begin
                rsp_late <= 1'b1;
                if (late_cnt != '1) begin
                    late_cnt <= late_cnt + 32'd1;
                end
            end
            if (addr_hs_i && full && !retire) begin
                overflow <= 1'b1;
            end
            if (rsp_hs_i && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign outstanding_o = count;
    assign oldest_age_o  = empty ? '0 : head_age;
    assign must_rsp_o    = must_rsp;
    assign rsp_late_o    = rsp_late;
    assign late_cnt_o    = late_cnt;
    assign overflow_o    = overflow;
    assign underflow_o   = underflow;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_cv32e40s_obi_latency_tracker.sv
`default_nettype none
// Self-checking bench: a timestamp queue models the outstanding transactions;
// scenario tasks compare the tracker outputs against it and against fixed values.
module tb_uvmt_cv32e40s_obi_latency_tracker;

    localparam int MAX_STALLS = 8;
    localparam int MAX_OUT    = 3;
    localparam int AGE_W      = 4;
    localparam int OUT_W      = 2;
    localparam int LIMIT      = MAX_STALLS + 1;
    localparam int AGE_SAT    = 15;

    logic             clk_i     = 1'b0;
    logic             rst_ni    = 1'b0;
    logic             clear_i   = 1'b0;
    logic             addr_hs_i = 1'b0;
    logic             rsp_hs_i  = 1'b0;
    logic [OUT_W-1:0] outstanding_o;
    logic [AGE_W-1:0] oldest_age_o;
    logic             must_rsp_o;
    logic             rsp_late_o;
    logic [31:0]      late_cnt_o;
    logic             overflow_o;
    logic             underflow_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int q[$];
    bit m_late, m_ovf, m_udf;
    int m_lcnt;

    uvmt_cv32e40s_obi_latency_tracker #(
        .MAX_STALLS      (MAX_STALLS),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .addr_hs_i     (addr_hs_i),
        .rsp_hs_i      (rsp_hs_i),
        .outstanding_o (outstanding_o),
        .oldest_age_o  (oldest_age_o),
        .must_rsp_o    (must_rsp_o),
        .rsp_late_o    (rsp_late_o),
        .late_cnt_o    (late_cnt_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int m_age();
        if (q.size() == 0) return 0;
        return ((cyc - q[0]) > AGE_SAT) ? AGE_SAT : (cyc - q[0]);
    endfunction

    function automatic void m_clear();
        q.delete();
        m_late = 0; m_ovf = 0; m_udf = 0; m_lcnt = 0;
    endfunction

    // Drives one cycle of handshakes and advances the scoreboard; returns 1 ns after the edge.
    task automatic tick(input logic a, input logic r, input logic clr);
        int  ha;
        bit  ret;
        @(negedge clk_i);
        addr_hs_i = a; rsp_hs_i = r; clear_i = clr;
        ha  = m_age();
        ret = r && (q.size() > 0);
        if (clr) begin
            m_clear();
        end else begin
            if ((q.size() > 0) && !r && (ha == LIMIT)) begin m_late = 1; m_lcnt++; end
            if (r && (q.size() == 0)) m_udf = 1;
            if (a && (q.size() == MAX_OUT) && !ret) m_ovf = 1;
            if (ret) void'(q.pop_front());
            if (a && (q.size() < MAX_OUT)) q.push_back(cyc);
        end
        @(posedge clk_i);
        cyc++;
        #1;
        addr_hs_i = 1'b0; rsp_hs_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        checks++; if (oldest_age_o !== '0) begin errors++; $display("FAIL reset_age: got %0d want 0", oldest_age_o); end
        checks++; if (must_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_must: got %b want 0", must_rsp_o); end
        checks++; if (late_cnt_o !== 32'd0 || rsp_late_o !== 1'b0) begin errors++; $display("FAIL reset_late: got %0d/%b want 0/0", late_cnt_o, rsp_late_o); end
        checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b want 0/0", overflow_o, underflow_o); end
        rst_ni = 1'b1;
        m_clear();
    endtask

    task automatic test_in_limit();
        tick(1, 0, 0);
        for (int k = 1; k <= LIMIT; k++) begin
            checks++; if (oldest_age_o !== AGE_W'(k)) begin errors++; $display("FAIL inlim_age: got %0d want %0d", oldest_age_o, k); end
            checks++; if (must_rsp_o !== (k == LIMIT)) begin errors++; $display("FAIL inlim_must@%0d: got %b want %b", k, must_rsp_o, (k == LIMIT)); end
            if (k < LIMIT) tick(0, 0, 0);
        end
        checks++; if (oldest_age_o !== AGE_W'(m_age())) begin errors++; $display("FAIL inlim_sb_age: got %0d want %0d", oldest_age_o, m_age()); end
        tick(0, 1, 0);
        checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL inlim_count: got %0d want 0", outstanding_o); end
        checks++; if (rsp_late_o !== 1'b0 || late_cnt_o !== 32'd0) begin errors++; $display("FAIL inlim_late: got %b/%0d want 0/0", rsp_late_o, late_cnt_o); end
    endtask

    task automatic test_late();
        tick(1, 0, 0);
        repeat (LIMIT - 1) tick(0, 0, 0);
        checks++; if (rsp_late_o !== 1'b0) begin errors++; $display("FAIL late_early: got %b want 0", rsp_late_o); end
        tick(0, 0, 0);
        checks++; if (rsp_late_o !== 1'b1 || late_cnt_o !== 32'd1) begin errors++; $display("FAIL late_set: got %b/%0d want 1/1", rsp_late_o, late_cnt_o); end
        checks++; if (must_rsp_o !== 1'b1 || oldest_age_o !== 4'd10) begin errors++; $display("FAIL late_must: got %b/%0d want 1/10", must_rsp_o, oldest_age_o); end
        tick(0, 0, 0);
        checks++; if (late_cnt_o !== 32'd1) begin errors++; $display("FAIL late_once: got %0d want 1", late_cnt_o); end
        tick(0, 0, 0);
        tick(0, 1, 0);
        checks++; if (outstanding_o !== '0 || rsp_late_o !== 1'b1 || late_cnt_o !== 32'd1) begin errors++; $display("FAIL late_after: got %0d/%b/%0d want 0/1/1", outstanding_o, rsp_late_o, late_cnt_o); end
        checks++; if (late_cnt_o !== 32'(m_lcnt)) begin errors++; $display("FAIL late_sb_cnt: got %0d want %0d", late_cnt_o, m_lcnt); end
    endtask

    task automatic test_saturation();
        tick(0, 0, 1);
        tick(1, 0, 0);
        repeat (20) tick(0, 0, 0);
        checks++; if (oldest_age_o !== 4'd15 || oldest_age_o !== AGE_W'(m_age())) begin errors++; $display("FAIL sat_age: got %0d want 15", oldest_age_o); end
        checks++; if (must_rsp_o !== 1'b1 || late_cnt_o !== 32'd1) begin errors++; $display("FAIL sat_late: got %b/%0d want 1/1", must_rsp_o, late_cnt_o); end
        tick(0, 1, 0);
    endtask

    task automatic test_multi();
        int exp_lat;
        tick(0, 0, 1);
        repeat (3) tick(1, 0, 0);
        checks++; if (outstanding_o !== 2'd3 || oldest_age_o !== 4'd3) begin errors++; $display("FAIL multi_fill: got %0d/%0d want 3/3", outstanding_o, oldest_age_o); end
        repeat (2) tick(0, 0, 0);
        exp_lat = m_age();
        checks++; if (oldest_age_o !== AGE_W'(exp_lat)) begin errors++; $display("FAIL multi_sb_head: got %0d want %0d", oldest_age_o, exp_lat); end
        tick(0, 1, 0);
        checks++; if (outstanding_o !== 2'd2 || oldest_age_o !== 4'd5) begin errors++; $display("FAIL multi_second: got %0d/%0d want 2/5", outstanding_o, oldest_age_o); end
    endtask

    task automatic test_back_to_back();
        tick(0, 0, 1);
        repeat (3) tick(1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            checks++; if (oldest_age_o !== 4'd3 || oldest_age_o !== AGE_W'(m_age())) begin errors++; $display("FAIL b2b_age[%0d]: got %0d want 3", k, oldest_age_o); end
            tick(1, 1, 0);
            checks++; if (outstanding_o !== 2'd3 || overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_count[%0d]: got %0d/%b want 3/0", k, outstanding_o, overflow_o); end
        end
        checks++; if (underflow_o !== 1'b0 || rsp_late_o !== 1'b0) begin errors++; $display("FAIL b2b_flags: got %b/%b want 0/0", underflow_o, rsp_late_o); end
    endtask

    task automatic test_errors();
        tick(0, 0, 1);
        tick(0, 1, 0);
        checks++; if (underflow_o !== 1'b1 || outstanding_o !== '0 || overflow_o !== 1'b0) begin errors++; $display("FAIL udf: got %b/%0d/%b want 1/0/0", underflow_o, outstanding_o, overflow_o); end
        repeat (3) tick(1, 0, 0);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow_o); end
        tick(1, 0, 0);
        checks++; if (overflow_o !== 1'b1 || outstanding_o !== 2'd3 || oldest_age_o !== 4'd4) begin errors++; $display("FAIL ovf: got %b/%0d/%0d want 1/3/4", overflow_o, outstanding_o, oldest_age_o); end
        checks++; if (overflow_o !== m_ovf || underflow_o !== m_udf) begin errors++; $display("FAIL ovf_sb: got %b/%b want %b/%b", overflow_o, underflow_o, m_ovf, m_udf); end
    endtask

    task automatic test_reset_mid();
        tick(0, 1, 0);
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL rst_pre: got %0d want 2", outstanding_o); end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checks++; if (outstanding_o !== '0 || oldest_age_o !== '0 || must_rsp_o !== 1'b0) begin errors++; $display("FAIL rst_async: got %0d/%0d/%b want 0/0/0", outstanding_o, oldest_age_o, must_rsp_o); end
        checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0 || rsp_late_o !== 1'b0 || late_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_flags: got %b/%b/%b/%0d want 0/0/0/0", overflow_o, underflow_o, rsp_late_o, late_cnt_o); end
        m_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(0, 1, 0);
        checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL rst_stale_rsp: got %b want 1", underflow_o); end
    endtask

    task automatic test_clear();
        tick(1, 0, 0);
        tick(1, 0, 1);
        checks++; if (outstanding_o !== '0 || underflow_o !== 1'b0) begin errors++; $display("FAIL clr: got %0d/%b want 0/0", outstanding_o, underflow_o); end
        tick(0, 0, 0);
        checks++; if (outstanding_o !== 2'(q.size()) || oldest_age_o !== '0) begin errors++; $display("FAIL clr_after: got %0d/%0d want 0/0", outstanding_o, oldest_age_o); end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_in_limit();
        test_late();
        test_saturation();
        test_multi();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
